// File: rtl/retry_ack_tracker_pkg.sv
// Shared definitions for the retry-buffer ack tracker: default sizing,
// the tracker state type and the free-request helper.
package retry_pkg;

  localparam int RETRY_BUF_DEPTH = 64;
  localparam int RETRY_ACK_GRAN  = 8;
  localparam int FREE_REQ_W      = 9;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_FULL   = 2'd1,
    ST_ERROR  = 2'd2
  } retry_ack_state_e;

  // Kept 9 bits wide so ack-bit granule plus a full 8-bit count never wraps.
  function automatic logic [FREE_REQ_W-1:0] calc_free_req(
    input logic                  ack_bit,
    input logic                  full_ack_vld,
    input logic [7:0]            full_ack_cnt,
    input logic [FREE_REQ_W-1:0] gran
  );
    logic [FREE_REQ_W-1:0] from_bit;
    logic [FREE_REQ_W-1:0] from_full;
    from_bit  = ack_bit ? gran : '0;
    from_full = full_ack_vld ? {1'b0, full_ack_cnt} : '0;
    return from_bit + from_full;
  endfunction

endpackage

// File: rtl/retry_ack_tracker_if.sv
// Allocation / acknowledge bundle between the link layer and the retry
// ack tracker. The tracker uses the slave view, its driver the master view.
interface retry_ack_tracker_if
  import retry_pkg::*;
#(
  parameter int DEPTH = RETRY_BUF_DEPTH
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             i_flit_alloc;
  logic             i_rx_ack_bit;
  logic             i_rx_full_ack_vld;
  logic [7:0]       i_rx_full_ack_cnt;
  logic             i_err_clr;

  logic [PTR_W-1:0] o_wr_ptr;
  logic [PTR_W-1:0] o_rd_ptr;
  logic [PTR_W:0]   o_num_free;
  logic             o_buf_full;
  logic             o_buf_empty;
  logic             o_alloc_stall;
  logic             o_ack_err;

  modport master (
    output i_flit_alloc, i_rx_ack_bit, i_rx_full_ack_vld, i_rx_full_ack_cnt, i_err_clr,
    input  o_wr_ptr, o_rd_ptr, o_num_free, o_buf_full, o_buf_empty, o_alloc_stall, o_ack_err
  );

  modport slave (
    input  i_flit_alloc, i_rx_ack_bit, i_rx_full_ack_vld, i_rx_full_ack_cnt, i_err_clr,
    output o_wr_ptr, o_rd_ptr, o_num_free, o_buf_full, o_buf_empty, o_alloc_stall, o_ack_err
  );

endinterface

// File: rtl/retry_ack_tracker_counter.sv
// Generic up/down counter: adds a multi-bit increment and subtracts a
// single-bit decrement each cycle; caller guarantees no over/underflow.
module nbit_up_dn_counter #(
  parameter int               WIDTH   = 7,
  parameter int               INC_W   = 9,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [INC_W-1:0] inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg + WIDTH'(inc) - WIDTH'(dec);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= RST_VAL;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/retry_ack_tracker.sv
// Retry-buffer pointer and free-count tracker driven by Ack bits and full-acks.
// Optional over-acknowledge error handling is enabled by RETRY_ACK_ERR_CHK_EN.
module retry_ack_tracker
  import retry_pkg::*;
#(
  parameter int DEPTH    = RETRY_BUF_DEPTH,
  parameter int ACK_GRAN = RETRY_ACK_GRAN
) (
  input  logic                i_clk,
  input  logic                i_rst,
  retry_ack_tracker_if.slave  bus
);

  localparam int                    PTR_W   = $clog2(DEPTH);
  localparam int                    CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(DEPTH);
  localparam logic [FREE_REQ_W-1:0] GRAN_C  = FREE_REQ_W'(ACK_GRAN);

  retry_ack_state_e        state_reg;
  retry_ack_state_e        state_next;
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [PTR_W-1:0]        rd_ptr_reg;
  logic [CNT_W-1:0]        num_free;
  logic [CNT_W-1:0]        num_free_next;
  logic [CNT_W-1:0]        occ;
  logic [FREE_REQ_W-1:0]   free_req;
  logic [FREE_REQ_W-1:0]   free_amt;
  logic                    over_ack;
  logic                    alloc_ok;

  // Occupancy is taken before any same-cycle allocation is applied.
  always_comb begin
    free_req = calc_free_req(bus.i_rx_ack_bit, bus.i_rx_full_ack_vld,
                             bus.i_rx_full_ack_cnt, GRAN_C);
    occ      = DEPTH_C - num_free;
    over_ack = free_req > FREE_REQ_W'(occ);
  end

  always_comb begin
    state_next    = state_reg;
    alloc_ok      = 1'b0;
    free_amt      = '0;
    num_free_next = num_free;
    case (state_reg)
      ST_NORMAL, ST_FULL: begin
`ifdef RETRY_ACK_ERR_CHK_EN
        if (over_ack) begin
          state_next = ST_ERROR;
        end else begin
          free_amt      = free_req;
          alloc_ok      = bus.i_flit_alloc && (state_reg == ST_NORMAL);
          num_free_next = num_free + CNT_W'(free_amt) - CNT_W'(alloc_ok);
          state_next    = (num_free_next == '0) ? ST_FULL : ST_NORMAL;
        end
`else
        // Over-acknowledge is clamped to whatever is actually outstanding.
        free_amt      = over_ack ? FREE_REQ_W'(occ) : free_req;
        alloc_ok      = bus.i_flit_alloc && (state_reg == ST_NORMAL);
        num_free_next = num_free + CNT_W'(free_amt) - CNT_W'(alloc_ok);
        state_next    = (num_free_next == '0) ? ST_FULL : ST_NORMAL;
`endif
      end
`ifdef RETRY_ACK_ERR_CHK_EN
      ST_ERROR: begin
        if (bus.i_err_clr) begin
          state_next = (num_free == '0) ? ST_FULL : ST_NORMAL;
        end
      end
`endif
      default: begin
        state_next = ST_NORMAL;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_NORMAL;
    end else begin
      state_reg <= state_next;
    end
  end

  // Truncating to PTR_W bits gives the mod-DEPTH wrap for free.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(alloc_ok);
      rd_ptr_reg <= rd_ptr_reg + PTR_W'(free_amt);
    end
  end

  nbit_up_dn_counter #(
    .WIDTH   (CNT_W),
    .INC_W   (FREE_REQ_W),
    .RST_VAL (DEPTH_C)
  ) u_free_cnt (
    .clk   (i_clk),
    .srst  (i_rst),
    .inc   (free_amt),
    .dec   (alloc_ok),
    .count (num_free)
  );

  assign bus.o_wr_ptr      = wr_ptr_reg;
  assign bus.o_rd_ptr      = rd_ptr_reg;
  assign bus.o_num_free    = num_free;
  assign bus.o_buf_full    = (num_free == '0);
  assign bus.o_buf_empty   = (num_free == DEPTH_C);
  assign bus.o_alloc_stall = (state_reg != ST_NORMAL);

`ifdef RETRY_ACK_ERR_CHK_EN
  assign bus.o_ack_err = (state_reg == ST_ERROR);
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.i_err_clr;
  assign bus.o_ack_err  = 1'b0;
`endif

endmodule

// File: tb/tb_retry_ack_tracker.sv
// Scoreboard bench for retry_ack_tracker: directed corner sequences plus
// random traffic, checked against an occupancy-level reference model.
module tb_retry_ack_tracker;

  localparam int DEPTH    = 64;
  localparam int ACK_GRAN = 8;
  localparam int PTR_W    = $clog2(DEPTH);

  typedef struct {
    string nm;
    int    wr;
    int    rd;
    int    nfree;
    bit    full;
    bit    empty;
    bit    stall;
    bit    err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  retry_ack_tracker_if #(.DEPTH(DEPTH)) bus ();

  retry_ack_tracker #(
    .DEPTH    (DEPTH),
    .ACK_GRAN (ACK_GRAN)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference state: outstanding entries, pointers, error flag.
  int   m_occ = 0;
  int   m_wr  = 0;
  int   m_rd  = 0;
  bit   m_err = 1'b0;

  task automatic step(input string nm, input bit a, input bit ack, input bit fv,
                      input int cnt, input bit clr, input bit r);
    exp_t e;
    int   fr;
    int   acc;
    @(posedge clk);
    #1;
    bus.i_flit_alloc      = a;
    bus.i_rx_ack_bit      = ack;
    bus.i_rx_full_ack_vld = fv;
    bus.i_rx_full_ack_cnt = 8'(cnt);
    bus.i_err_clr         = clr;
    rst                   = r;
    fr = (ack ? ACK_GRAN : 0) + (fv ? cnt : 0);
    if (r) begin
      m_occ = 0; m_wr = 0; m_rd = 0; m_err = 1'b0;
    end else if (m_err) begin
      if (clr) m_err = 1'b0;
    end else begin
      acc = (a && m_occ < DEPTH) ? 1 : 0;
      if (fr > m_occ) begin
`ifdef RETRY_ACK_ERR_CHK_EN
        m_err = 1'b1;
`else
        m_rd  = (m_rd + m_occ) % DEPTH;
        m_occ = acc;
        m_wr  = (m_wr + acc) % DEPTH;
`endif
      end else begin
        m_rd  = (m_rd + fr) % DEPTH;
        m_occ = m_occ - fr + acc;
        m_wr  = (m_wr + acc) % DEPTH;
      end
    end
    e.nm    = nm;
    e.wr    = m_wr;
    e.rd    = m_rd;
    e.nfree = DEPTH - m_occ;
    e.full  = (m_occ == DEPTH);
    e.empty = (m_occ == 0);
    e.stall = m_err || (m_occ == DEPTH);
    e.err   = m_err;
    sb_q.push_back(e);
  endtask

  task automatic idle(input string nm);
    step(nm, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic allocs(input string nm, input int n);
    for (int i = 0; i < n; i++) step(nm, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Monitor: the DUT presents fresh outputs every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb_q.size() > 0) begin
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        txn++;
        if (int'(bus.o_wr_ptr) != e.wr || int'(bus.o_rd_ptr) != e.rd ||
            int'(bus.o_num_free) != e.nfree || bus.o_buf_full != e.full ||
            bus.o_buf_empty != e.empty || bus.o_alloc_stall != e.stall ||
            bus.o_ack_err != e.err) begin
          errors++;
          $display("FAIL txn %0d %s: got wr=%0d rd=%0d free=%0d full=%0b empty=%0b stall=%0b err=%0b, want wr=%0d rd=%0d free=%0d full=%0b empty=%0b stall=%0b err=%0b",
                   txn, e.nm, bus.o_wr_ptr, bus.o_rd_ptr, bus.o_num_free, bus.o_buf_full,
                   bus.o_buf_empty, bus.o_alloc_stall, bus.o_ack_err,
                   e.wr, e.rd, e.nfree, e.full, e.empty, e.stall, e.err);
        end else begin
          $display("txn %0d %s: wr=%0d rd=%0d free=%0d stall=%0b err=%0b", txn, e.nm,
                   bus.o_wr_ptr, bus.o_rd_ptr, bus.o_num_free, bus.o_alloc_stall, bus.o_ack_err);
        end
      end
    end
  end

  initial begin
    int cnt;
    bus.i_flit_alloc      = 1'b0;
    bus.i_rx_ack_bit      = 1'b0;
    bus.i_rx_full_ack_vld = 1'b0;
    bus.i_rx_full_ack_cnt = 8'd0;
    bus.i_err_clr         = 1'b0;

    // Fill to full, then one refused allocation.
    step("reset", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    allocs("fill", DEPTH);
    allocs("alloc_when_full", 1);
    idle("hold_full");

    // occ 64 -> 20 via full-ack, then ack bit, then combined ack with alloc.
    step("fullack44", 1'b0, 1'b0, 1'b1, 44, 1'b0, 1'b0);
    step("ackbit_occ20", 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    step("fullack2", 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    step("ack_alloc_occ10", 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0);

    // Read pointer wrap from 60 to 4.
    step("reset2", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    allocs("to60", 60);
    step("free60", 1'b0, 1'b0, 1'b1, 60, 1'b0, 1'b0);
    allocs("wrap8", 8);
    step("free8_wrap", 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0);

    // Over-acknowledge with occ 5.
    step("reset3", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    allocs("occ5", 5);
    step("overack_occ5", 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    allocs("alloc_after_overack", 1);
    step("free_after_overack", 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    step("err_clr", 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    allocs("alloc_after_clr", 1);
    step("zero_free", 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);

    // Over-ack at occ 30 then reset with other inputs active.
    step("reset4", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    allocs("occ30", 30);
    step("overack_occ30", 1'b1, 1'b1, 1'b1, 200, 1'b0, 1'b0);
    allocs("in_err", 1);
    step("reset_prio", 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1);
    idle("post_reset");

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      cnt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 10);
      step("rand",
           $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 20,
           cnt,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 1);
    end
    idle("drain");

    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
